// File: rtl/result_collector_pkg.sv
// accel_pkg: shared defaults and types for the result collector slice.
//   DEFAULT_* : default widths / channel count used by the interface and top
//   state_t   : collector FSM encoding (IDLE, COLLECT, FLUSH)
//   result_t  : signed result word at the default data width
package accel_pkg;

  localparam int DEFAULT_NUM_ALLOCATORS = 4;
  localparam int DEFAULT_DATA_WIDTH     = 18;
  localparam int DEFAULT_ADDR_WIDTH     = 16;
  localparam int DEFAULT_COUNT_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] result_t;

endpackage

// File: rtl/result_collector_if.sv
// result_collector_if: control, allocator and output-memory signals of the
// result collector.
//   master : upstream side (drives image/round control and allocator results)
//   slave  : collector side (drives the output memory write port and status)
interface result_collector_if import accel_pkg::*; #(
  parameter int NUM_ALLOCATORS = DEFAULT_NUM_ALLOCATORS,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH
);
  localparam int RA_W = $clog2(NUM_ALLOCATORS) + 1;

  logic                               image_start;
  logic [ADDR_WIDTH-1:0]              output_memory_offset;
  logic [COUNT_WIDTH-1:0]             total_outputs;
  logic                               round_start;
  logic [RA_W-1:0]                    round_active;
  logic [NUM_ALLOCATORS-1:0]          alloc_done;
  logic [NUM_ALLOCATORS*DATA_WIDTH-1:0] alloc_data;
  logic [ADDR_WIDTH-1:0]              out_mem_addr;
  logic [DATA_WIDTH-1:0]              out_mem_data;
  logic                               out_mem_en;
  logic                               round_done;
  logic                               image_done;
  logic                               err_overflow;
  logic                               err_protocol;

  modport master (
    output image_start, output_memory_offset, total_outputs,
    output round_start, round_active, alloc_done, alloc_data,
    input  out_mem_addr, out_mem_data, out_mem_en,
    input  round_done, image_done, err_overflow, err_protocol
  );

  modport slave (
    input  image_start, output_memory_offset, total_outputs,
    input  round_start, round_active, alloc_done, alloc_data,
    output out_mem_addr, out_mem_data, out_mem_en,
    output round_done, image_done, err_overflow, err_protocol
  );
endinterface

// File: rtl/result_collector_slot.sv
// result_slot: one-deep result buffer for a single allocator channel.
//   capture_i  : allocator result valid (already range-filtered by the top)
//   wr_i       : this slot is being drained to memory this cycle
//   data_i     : incoming result
//   valid_o    : slot holds an unwritten result
//   data_o     : buffered result
//   overflow_o : capture arrived while holding a result that is not being drained
module result_slot #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         capture_i,
  input  logic                         wr_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic                         valid_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         overflow_o
);
  logic                         valid_q, valid_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    overflow_o = 1'b0;
    if (wr_i) valid_d = 1'b0;
    if (capture_i) begin
      // A drain in the same cycle frees the slot, so the new result refills it.
      if (!valid_q || wr_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else begin
        overflow_o = 1'b1;  // keep the older result, drop the new one
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/result_collector.sv
// result_collector: buffers one result per allocator and writes them to the
// output memory in allocator-index order, tracking round and image completion.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : result_collector_if.slave (control, allocator results,
//              output memory write port, status/error flags)
// Build option: define RESULT_COLLECTOR_RELU_EN to clamp negative results to
// zero on the write path (same timing either way).
module result_collector import accel_pkg::*; #(
  parameter int NUM_ALLOCATORS = DEFAULT_NUM_ALLOCATORS,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  result_collector_if.slave bus
);
  localparam int RA_W = $clog2(NUM_ALLOCATORS) + 1;

  state_t                       state_q;
  logic [RA_W-1:0]              active_q, ptr_q;
  logic [ADDR_WIDTH-1:0]        write_count_q, write_count_d, write_base;
  logic [COUNT_WIDTH-1:0]       out_count_q, out_count_d, count_base;
  logic [COUNT_WIDTH-1:0]       total_q, total_d;
  logic                         armed_q;
  logic [ADDR_WIDTH-1:0]        out_mem_addr_q;
  logic signed [DATA_WIDTH-1:0] out_mem_data_q, sel_data, wr_data;
  logic                         out_mem_en_q, round_done_q, image_done_q;
  logic                         err_overflow_q, err_protocol_q;
  logic                         sel_valid, write_fire, proto_evt;

  logic [NUM_ALLOCATORS-1:0]    capture, slot_wr, slot_valid, slot_ovf;
  logic signed [DATA_WIDTH-1:0] slot_data [NUM_ALLOCATORS];

  generate
    for (genvar gi = 0; gi < NUM_ALLOCATORS; gi++) begin : g_slot
      // Out-of-round channels are only rejected while a round is draining;
      // outside COLLECT any channel may finish early.
      assign capture[gi] = bus.alloc_done[gi] &
                           ((RA_W'(gi) < active_q) || (state_q != COLLECT));
      assign slot_wr[gi] = write_fire && (ptr_q == RA_W'(gi));

      result_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .capture_i  (capture[gi]),
        .wr_i       (slot_wr[gi]),
        .data_i     (bus.alloc_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .valid_o    (slot_valid[gi]),
        .data_o     (slot_data[gi]),
        .overflow_o (slot_ovf[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_ALLOCATORS; i++) begin
      if (ptr_q == RA_W'(i)) begin
        sel_valid = slot_valid[i];
        sel_data  = slot_data[i];
      end
    end
  end

  assign write_fire = (state_q == COLLECT) && sel_valid;

`ifdef RESULT_COLLECTOR_RELU_EN
  assign wr_data = sel_data[DATA_WIDTH-1] ? '0 : sel_data;
`else
  assign wr_data = sel_data;
`endif

  // image_start clears the counters first, so a coincident write lands at offset+0.
  always_comb begin
    write_base    = bus.image_start ? '0 : write_count_q;
    count_base    = bus.image_start ? '0 : out_count_q;
    total_d       = bus.image_start ? bus.total_outputs : total_q;
    write_count_d = write_fire ? write_base + ADDR_WIDTH'(1) : write_base;
    // Output count saturates at the target so image_done stays high.
    out_count_d   = (write_fire && (count_base != total_d)) ?
                    count_base + COUNT_WIDTH'(1) : count_base;
    proto_evt     = (|(bus.alloc_done & ~capture)) ||
                    (bus.round_start && (state_q != IDLE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      active_q       <= '0;
      ptr_q          <= '0;
      write_count_q  <= '0;
      out_count_q    <= '0;
      total_q        <= '0;
      armed_q        <= 1'b0;
      out_mem_addr_q <= '0;
      out_mem_data_q <= '0;
      out_mem_en_q   <= 1'b0;
      round_done_q   <= 1'b0;
      image_done_q   <= 1'b0;
      err_overflow_q <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      out_mem_en_q   <= write_fire;
      round_done_q   <= 1'b0;
      if (write_fire) begin
        out_mem_addr_q <= bus.output_memory_offset + write_base;
        out_mem_data_q <= wr_data;
      end
      write_count_q  <= write_count_d;
      out_count_q    <= out_count_d;
      total_q        <= total_d;
      armed_q        <= armed_q | bus.image_start;
      // No image has been configured until the first image_start.
      image_done_q   <= (armed_q | bus.image_start) && (out_count_d == total_d);
      err_overflow_q <= (err_overflow_q & ~bus.image_start) | (|slot_ovf);
      err_protocol_q <= (err_protocol_q & ~bus.image_start) | proto_evt;

      case (state_q)
        IDLE: begin
          if (bus.round_start) begin
            active_q <= bus.round_active;
            ptr_q    <= '0;
            state_q  <= COLLECT;
          end
        end
        COLLECT: begin
          if (write_fire) begin
            if (ptr_q == active_q - RA_W'(1)) state_q <= FLUSH;
            else                              ptr_q   <= ptr_q + RA_W'(1);
          end
        end
        FLUSH: begin
          round_done_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_mem_addr = out_mem_addr_q;
  assign bus.out_mem_data = out_mem_data_q;
  assign bus.out_mem_en   = out_mem_en_q;
  assign bus.round_done   = round_done_q;
  assign bus.image_done   = image_done_q;
  assign bus.err_overflow = err_overflow_q;
  assign bus.err_protocol = err_protocol_q;
endmodule
